// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // The iteration counter must be able to hold the value WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_controller.sv
// Sequencing FSM and iteration counter for seq_multiplier.
//   state | meaning
//   IDLE  | waiting for start, product holds the last result
//   CALC  | one multiplier bit retired per clock
//   DONE  | product valid for this single cycle, new start accepted
module mul_controller
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic load,
    output logic step,
    output logic finish,
    output logic ready,
    output logic busy,
    output logic done
);

    localparam int CNT_W = cnt_width(WIDTH);

    mul_state_e       state;
    mul_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last;

    // The edge that performs iteration WIDTH is also the edge that enters DONE.
    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready  = (state == IDLE) || (state == DONE);
        busy   = (state == CALC);
        done   = (state == DONE);
        load   = start && ready;
        step   = busy;
        finish = busy && last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, WIDTH cycles per product, start/done handshake.
// Define MUL_SIGNED_EN to add the signed_mode port and sign-magnitude handling.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
`ifdef MUL_SIGNED_EN
    input  logic               signed_mode,
`endif
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic               load;
    logic               step;
    logic               finish;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] p_reg;
    logic [2*WIDTH-1:0] p_next;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   a_load;
    logic [WIDTH-1:0]   b_load;
    logic [2*WIDTH-1:0] result;

    mul_controller #(.WIDTH(WIDTH)) u_ctrl (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .load   (load),
        .step   (step),
        .finish (finish),
        .ready  (ready),
        .busy   (busy),
        .done   (done)
    );

    // Add into the upper half with a carry, then shift {carry, P} right by one.
    always_comb begin
        sum    = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + {1'b0, (b_reg[0] ? a_reg : '0)};
        p_next = (2*WIDTH)'({sum, p_reg[WIDTH-1:0]} >> 1);
    end

`ifdef MUL_SIGNED_EN
    logic sign_reg;

    // Magnitudes are taken as unsigned so the most negative operand survives.
    always_comb begin
        a_load = (signed_mode && a_in[WIDTH-1]) ? (~a_in + WIDTH'(1)) : a_in;
        b_load = (signed_mode && b_in[WIDTH-1]) ? (~b_in + WIDTH'(1)) : b_in;
        result = sign_reg ? (~p_next + (2*WIDTH)'(1)) : p_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_reg <= 1'b0;
        end else if (load) begin
            sign_reg <= signed_mode && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
        end
    end
`else
    always_comb begin
        a_load = a_in;
        b_load = b_in;
        result = p_next;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            p_reg <= '0;
        end else if (load) begin
            a_reg <= a_load;
            b_reg <= b_load;
            p_reg <= '0;
        end else if (step) begin
            b_reg <= b_reg >> 1;
            p_reg <= p_next;
        end
    end

    // Result is exposed only once the last iteration completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
        end else if (finish) begin
            product <= result;
        end
    end

endmodule
